clint_vec: RTL and testbench
============================

# clint_vec

Core-local interrupt controller for the rv32i core: arbitrates `NUM_IRQ` level-sensitive external/timer sources plus synchronous ECALL/EBREAK/illegal-instruction exceptions. It sequences the mepc/mstatus/mcause CSR writes, then redirects the ex stage to the trap target, either direct or vectored per mtvec.MODE. It also handles MRET. It sits between id/ex, ctrl (pipeline hold) and csr_reg.

## Interface
- `NUM_IRQ`, 4: number of async interrupt sources, 1..16
- `IRQ_CAUSE_BASE`, 16: mcause exception code of source 0; source i uses `IRQ_CAUSE_BASE+i`
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `irq_i`  in  NUM_IRQ  level interrupt requests, bit 0 highest priority
- `inst_i`  in  32  instruction word in id
- `inst_addr_i`  in  32  address of `inst_i`
- `illegal_i`  in  1  id flags `inst_i` illegal
- `jump_flag_i`, `jump_addr_i`  in  1, 32  ex-stage taken jump and its target
- `csr_mie_i`  in  NUM_IRQ  per-source enable (csr_reg mie, low bits)
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i`  in  32 each  current CSR values
- `hold_flag_o`  out  1  pipeline hold to ctrl
- `we_o`  out  1  CSR write enable
- `waddr_o`  out  32  CSR write address, `{20'h0, csr12}`
- `data_o`  out  32  CSR write data
- `int_assert_o`  out  1  one-cycle redirect pulse to ex
- `int_addr_o`  out  32  redirect target, valid with `int_assert_o`
- `irq_claim_o`  out  NUM_IRQ  one-hot of the serviced source, pulsed with `int_assert_o`

## Operation
- States: IDLE, MEPC, MSTATUS, MCAUSE, ASSERT, MRET_MSTATUS, MRET_ASSERT.
- All outputs are decoded from the state register and captured registers. They are zero in IDLE and after reset.
- Decision in IDLE each cycle. Priority order:
  1. sync exception: ECALL, cause 11; EBREAK, cause 3; `illegal_i`, cause 2
  2. async: `mstatus[3]` (MIE) = 1 and `(irq_i & csr_mie_i) != 0`; the lowest set index wins; cause `{1'b1, 31'(IRQ_CAUSE_BASE+idx)}`
  3. MRET instruction
  4. otherwise stay in IDLE
- Trap entry captures cause, source one-hot, epc and target, then goes to MEPC.
  - Sync epc is `inst_addr_i`.
  - Async epc is `jump_addr_i` if `jump_flag_i`, else `inst_addr_i`.
- Trap target:
  - mtvec[1:0]=0: `{mtvec[31:2],2'b00}`
  - mtvec[1:0]=1 and async: base + 4*(IRQ_CAUSE_BASE+idx)
  - mtvec[1:0]=1 and sync: base
  - mtvec[1:0]=2 or 3: treated as 0
- MEPC: write mepc (0x341) = epc.
- MSTATUS: write mstatus (0x300) = current with MPIE[7] ← MIE[3] and MIE ← 0.
- MCAUSE: write mcause (0x342) = cause.
- ASSERT: drive `int_assert_o=1`, `int_addr_o`=target, `irq_claim_o`=one-hot; no CSR write. Next state IDLE.
- MRET_MSTATUS: write mstatus with MIE ← MPIE and MPIE ← 1.
- MRET_ASSERT: pulse `int_assert_o` with `int_addr_o = csr_mepc_i`; next state IDLE.
- `hold_flag_o` = (decision taken in IDLE this cycle) | (state != IDLE).

## Timing
- Trap taken at cycle T, with hold high in T:
  - T+1: mepc write
  - T+2: mstatus write
  - T+3: mcause write
  - T+4: redirect pulse
  - T+5: IDLE; a new decision is possible in T+5
- MRET at cycle T: T+1 mstatus write, T+2 redirect to mepc, T+3 IDLE.
- Exactly one `we_o` cycle per CSR write.
- `irq_i` and `inst_i` changes after the decision are ignored; a source dropping mid-sequence does not abort the trap.
- Simultaneous events:
  - exception and irq: the exception wins; the irq is re-evaluated in T+5 but is blocked because MIE=0.
  - irq and MRET: the irq wins.
- `rst` in any state: next cycle IDLE, all outputs 0, no partial CSR write completes; captured registers are cleared.

## Test plan
- irq_i=4'b0110, mie=4'b1111, mstatus=0x8, mtvec=0x100, inst_addr=0x40 -> writes mepc=0x40, mstatus=0x80, mcause=0x80000011; redirect 0x100 at T+4; irq_claim_o=0010.
- Same, mtvec=0x101 -> redirect 0x101&~3 + 4*17 = 0x144.
- ECALL at 0x80 while irq_i=1, MIE=1 -> mcause=11, mepc=0x80; no claim; hold high for T..T+4.
- Async with jump_flag_i=1, jump_addr_i=0x200 -> mepc=0x200; irq masked by mie=0 or MIE=0 -> no trap, hold low.
- MRET, mstatus=0x80, mepc=0x44 -> mstatus write 0x88 at T+1; redirect 0x44 at T+2.
- `rst` asserted during MSTATUS state -> next cycle we_o=0, int_assert_o=0, hold_flag_o=0, no mcause write.

Source files
------------

// File: rtl/clint_vec.sv
// clint_vec - core-local interrupt controller for the rv32i core.
//
// Arbitrates synchronous exceptions (ECALL, EBREAK, illegal instruction)
// against NUM_IRQ level-sensitive interrupt sources. It also handles MRET.
// On trap entry it writes mepc, mstatus and mcause through the CSR write
// port, one CSR per cycle. It then pulses a redirect to the trap target,
// which is either direct or vectored according to mtvec.MODE.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   irq_i, csr_mie_i    interrupt levels (bit 0 highest) and per-source enables
//   inst_i, inst_addr_i instruction in id and its address
//   illegal_i           id flags inst_i illegal
//   jump_flag_i/addr_i  ex-stage taken jump (used as epc for async traps)
//   csr_*_i             current mtvec/mepc/mstatus values
//   hold_flag_o         pipeline hold to ctrl
//   we_o/waddr_o/data_o CSR write port
//   int_assert_o/addr_o one-cycle redirect to ex
//   irq_claim_o         one-hot of the serviced source, pulsed with the redirect
module clint_vec #(
   parameter int NUM_IRQ        = 4,
   parameter int IRQ_CAUSE_BASE = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [31:0]        inst_i,
   input  logic [31:0]        inst_addr_i,
   input  logic               illegal_i,
   input  logic               jump_flag_i,
   input  logic [31:0]        jump_addr_i,
   input  logic [NUM_IRQ-1:0] csr_mie_i,
   input  logic [31:0]        csr_mtvec_i,
   input  logic [31:0]        csr_mepc_i,
   input  logic [31:0]        csr_mstatus_i,
   output logic               hold_flag_o,
   output logic               we_o,
   output logic [31:0]        waddr_o,
   output logic [31:0]        data_o,
   output logic               int_assert_o,
   output logic [31:0]        int_addr_o,
   output logic [NUM_IRQ-1:0] irq_claim_o
);

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

   typedef enum logic [2:0] {
      S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_MRET_MSTATUS, S_MRET_ASSERT
   } state_t;

   state_t             r_state, w_next;
   logic [31:0]        r_cause, r_epc, r_target;
   logic [NUM_IRQ-1:0] r_claim;

   logic               w_ecall, w_ebreak, w_mret, w_exc, w_async, w_trap, w_decide;
   logic [NUM_IRQ-1:0] w_pend, w_claim;
   logic [4:0]         w_idx;
   logic [31:0]        w_irq_code, w_base, w_cause, w_epc, w_target;

   // ---------------- IDLE decision (combinational) ----------------
   always_comb begin
      w_ecall  = (inst_i == INST_ECALL);
      w_ebreak = (inst_i == INST_EBREAK);
      w_mret   = (inst_i == INST_MRET);
      w_exc    = w_ecall | w_ebreak | illegal_i;
      w_pend   = irq_i & csr_mie_i;
      w_async  = csr_mstatus_i[3] & (|w_pend);
      w_trap   = w_exc | w_async;
      w_decide = w_trap | w_mret;

      // Walk downward so the lowest pending index is the final winner.
      w_idx   = '0;
      w_claim = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_pend[i]) begin
            w_idx      = 5'(i);
            w_claim    = '0;
            w_claim[i] = 1'b1;
         end
      end

      w_irq_code = 32'(IRQ_CAUSE_BASE) + {27'b0, w_idx};
      w_base     = {csr_mtvec_i[31:2], 2'b00};

      if (w_exc) begin
         w_cause  = w_ecall ? 32'd11 : (w_ebreak ? 32'd3 : 32'd2);
         w_epc    = inst_addr_i;
         w_target = w_base;         // sync traps never vector
      end else begin
         w_cause  = {1'b1, w_irq_code[30:0]};
         w_epc    = jump_flag_i ? jump_addr_i : inst_addr_i;
         // MODE 2/3 are reserved and fall back to direct mode.
         w_target = (csr_mtvec_i[1:0] == 2'b01) ? (w_base + (w_irq_code << 2)) : w_base;
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_trap)      w_next = S_MEPC;
            else if (w_mret) w_next = S_MRET_MSTATUS;
         end
         S_MEPC:         w_next = S_MSTATUS;
         S_MSTATUS:      w_next = S_MCAUSE;
         S_MCAUSE:       w_next = S_ASSERT;
         S_ASSERT:       w_next = S_IDLE;
         S_MRET_MSTATUS: w_next = S_MRET_ASSERT;
         S_MRET_ASSERT:  w_next = S_IDLE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cause  <= '0;
         r_epc    <= '0;
         r_target <= '0;
         r_claim  <= '0;
      end else begin
         r_state <= w_next;
         // Capture everything at the decision so later input changes are ignored.
         if (r_state == S_IDLE && w_trap) begin
            r_cause  <= w_cause;
            r_epc    <= w_epc;
            r_target <= w_target;
            r_claim  <= w_exc ? '0 : w_claim;
         end
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      we_o         = 1'b0;
      waddr_o      = '0;
      data_o       = '0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;
      irq_claim_o  = '0;
      // Hold is raised in the decision cycle itself so id/ex freeze immediately.
      hold_flag_o  = (r_state != S_IDLE) | (w_decide & ~rst);
      case (r_state)
         S_MEPC: begin
            we_o    = 1'b1;
            waddr_o = CSR_MEPC;
            data_o  = r_epc;
         end
         S_MSTATUS: begin
            // MPIE <- MIE, MIE <- 0
            we_o    = 1'b1;
            waddr_o = CSR_MSTATUS;
            data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4], 1'b0,
                       csr_mstatus_i[2:0]};
         end
         S_MCAUSE: begin
            we_o    = 1'b1;
            waddr_o = CSR_MCAUSE;
            data_o  = r_cause;
         end
         S_ASSERT: begin
            int_assert_o = 1'b1;
            int_addr_o   = r_target;
            irq_claim_o  = r_claim;
         end
         S_MRET_MSTATUS: begin
            // MIE <- MPIE, MPIE <- 1
            we_o    = 1'b1;
            waddr_o = CSR_MSTATUS;
            data_o  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4], csr_mstatus_i[7],
                       csr_mstatus_i[2:0]};
         end
         S_MRET_ASSERT: begin
            int_assert_o = 1'b1;
            int_addr_o   = csr_mepc_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_clint_vec.sv
module tb_clint_vec;
   localparam int N    = 4;
   localparam int BASE = 16;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  irq, mie;
   logic [31:0]   inst, addr, ja, mtvec, mepc, mst;
   logic          illegal, jf;

   logic          hold_flag_o, we_o, int_assert_o;
   logic [31:0]   waddr_o, data_o, int_addr_o;
   logic [N-1:0]  irq_claim_o;

   clint_vec #(.NUM_IRQ(N), .IRQ_CAUSE_BASE(BASE)) dut (
      .clk(clk), .rst(rst), .irq_i(irq), .inst_i(inst), .inst_addr_i(addr),
      .illegal_i(illegal), .jump_flag_i(jf), .jump_addr_i(ja), .csr_mie_i(mie),
      .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mst),
      .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
      .int_assert_o(int_assert_o), .int_addr_o(int_addr_o), .irq_claim_o(irq_claim_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        hold;
      logic        we;
      logic [31:0] waddr;
      logic [31:0] data;
      logic        ia;
      logic [31:0] iaddr;
      logic [N-1:0] claim;
   } obs_t;

   obs_t obs;
   assign obs = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o, irq_claim_o};

   obs_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   function automatic obs_t mk(logic h, logic w, logic [31:0] wa, logic [31:0] d,
                               logic a, logic [31:0] ad, logic [N-1:0] c);
      obs_t o;
      o.hold = h; o.we = w; o.waddr = wa; o.data = d; o.ia = a; o.iaddr = ad; o.claim = c;
      return o;
   endfunction

   task automatic check(input string tag, input obs_t e);
      total++;
      assert (obs === e) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
   endtask

   // Reference model: expected per-cycle output sequence from the decision
   // inputs currently applied, derived directly from the trap rules.
   task automatic build_model();
      int          code;
      int          idx;
      bit          async;
      logic [31:0] epc, cause, tgt, base, mw;
      logic [N-1:0] pend, claim;
      code = -1;
      if (inst == ECALL)       code = 11;
      else if (inst == EBREAK) code = 3;
      else if (illegal)        code = 2;
      pend  = irq & mie;
      async = mst[3] && (pend != 0);
      idx   = 0;
      for (int i = N - 1; i >= 0; i--) if (pend[i]) idx = i;
      base  = mtvec & ~32'd3;
      if (code >= 0 || async) begin
         if (code >= 0) begin
            epc   = addr;
            cause = code;
            claim = '0;
            tgt   = base;
         end else begin
            epc   = jf ? ja : addr;
            cause = 32'h8000_0000 | (BASE + idx);
            claim = '0;
            claim[idx] = 1'b1;
            tgt   = ((mtvec & 3) == 1) ? base + 4 * (BASE + idx) : base;
         end
         mw = (mst & ~32'h88) | (((mst >> 3) & 1) << 7);
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(1, 1, 32'h341, epc, 0, 0, 0));
         exp_q.push_back(mk(1, 1, 32'h300, mw, 0, 0, 0));
         exp_q.push_back(mk(1, 1, 32'h342, cause, 0, 0, 0));
         exp_q.push_back(mk(1, 0, 0, 0, 1, tgt, claim));
      end else if (inst == MRET) begin
         mw = (mst & ~32'h88) | (((mst >> 7) & 1) << 3) | 32'h80;
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
         exp_q.push_back(mk(1, 1, 32'h300, mw, 0, 0, 0));
         exp_q.push_back(mk(1, 0, 0, 0, 1, mepc, 0));
      end else begin
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end
   endtask

   // Runs one decision and its whole sequence. With scramble set, the
   // non-CSR inputs are randomised after the decision and must be ignored.
   task automatic run(input string tag, input bit scramble);
      build_model();
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check(tag, exp_q.pop_front());
         @(posedge clk); #1;
         if (scramble) begin
            irq     = N'($urandom);
            inst    = $urandom;
            illegal = 1'($urandom);
            jf      = 1'($urandom);
            ja      = $urandom;
         end
      end
   endtask

   task automatic quiet();
      irq = '0; inst = NOP; illegal = 0; jf = 0; ja = 0;
   endtask

   initial begin
      rst = 1; irq = 4'b0110; mie = 4'hf; mst = 32'h8; mtvec = 32'h100; mepc = 0;
      inst = NOP; addr = 32'h40; illegal = 0; jf = 0; ja = 0;

      // reset: all outputs zero even with a pending enabled interrupt
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset", mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      rst = 0;

      // async, direct mode
      irq = 4'b0110; mie = 4'hf; mst = 32'h8; mtvec = 32'h100; addr = 32'h40;
      run("irq_direct", 0);
      // async, vectored mode
      mtvec = 32'h101;
      run("irq_vectored", 0);
      // reserved MODE=3 behaves as direct
      mtvec = 32'h103;
      run("irq_mode3", 0);

      // ECALL beats a pending irq
      mtvec = 32'h100; irq = 4'b0001; inst = ECALL; addr = 32'h80;
      run("ecall", 0);
      // irq re-evaluated after the trap is blocked by MIE=0 (mstatus as written)
      inst = NOP; mst = 32'h80;
      run("irq_blocked", 0);

      // EBREAK and illegal with vectored mtvec: sync traps go to base
      mst = 32'h8; mtvec = 32'h201; irq = 0; inst = EBREAK; addr = 32'h90;
      run("ebreak", 0);
      inst = NOP; illegal = 1; addr = 32'h94;
      run("illegal", 0);
      illegal = 0;

      // async epc from a taken jump
      mtvec = 32'h100; irq = 4'b0100; jf = 1; ja = 32'h200; addr = 32'h48;
      run("irq_jump", 0);
      jf = 0;

      // masked irqs: no trap, hold low
      irq = 4'b1111; mie = 4'h0; mst = 32'h8;
      run("mask_mie", 0);
      mie = 4'hf; mst = 32'h0;
      run("mask_mstatus", 0);

      // MRET
      irq = 0; inst = MRET; mst = 32'h80; mepc = 32'h44;
      run("mret", 0);
      // irq beats MRET
      irq = 4'b1000; mst = 32'h88;
      run("irq_over_mret", 0);
      quiet();

      // reset during MSTATUS aborts the sequence
      irq = 4'b0010; mst = 32'h8; mtvec = 32'h100;
      @(negedge clk);
      check("rst_decide", mk(1, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_in_mstatus", mk(1, 1, 32'h300, 32'h80, 0, 0, 0));
      rst = 1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_next", mk(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      rst = 0; irq = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_no_mcause", mk(0, 0, 0, 0, 0, 0, 0));
         @(posedge clk); #1;
      end

      // randomized traffic against the model
      for (int it = 0; it < 200; it++) begin
         case ($urandom_range(0, 4))
            0: inst = ECALL;
            1: inst = EBREAK;
            2: inst = MRET;
            3: inst = $urandom;
            default: inst = NOP;
         endcase
         illegal = ($urandom_range(0, 3) == 0);
         irq     = N'($urandom);
         mie     = N'($urandom);
         mst     = $urandom;
         mtvec   = $urandom;
         mepc    = $urandom;
         addr    = $urandom & ~32'd3;
         jf      = 1'($urandom);
         ja      = $urandom & ~32'd3;
         run("random", 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
